pkt_rx_checker: RTL
===================

Name: pkt_rx_checker

Overview:
- Receive-side consumer of the packetised ADC stream (ADC_DATA / ADC_DATA_VALID).
- Drives DATA_RD_EN, deframes packets, and checks header sequence, payload pattern and packet length against the self-test pattern.
- Sits in the pktctrl_clk domain beside the packet controller. Used in self-test bring-up and as a loopback checker on the capture path.
- Results go to MDIO-readable status registers.

Parameters:
- DATA_W, 18, stream word width.
- CNT_W, 16, width of the packet counter and the bad-packet counter.

Ports:
- pktctrl_clk  in  1  pktctrl clock; the only clock.
- pktctrl_rstn  in  1  asynchronous active-low reset.
- rf_chk_en  in  1  checker enable (level).
- rf_chk_clear  in  1  single-cycle pulse; clears counters and sticky flags.
- rf_pkt_data_length  in  2  payload length select: 0=64, 1=128, 2=256, 3=512 words.
- DATA_RD_EN  out  1  read enable to the packet source.
- ADC_DATA  in  DATA_W  stream word.
- ADC_DATA_VALID  in  1  word qualifier.
- chk_busy  out  1  high in HDR or PAYLOAD state.
- chk_pkt_cnt  out  CNT_W  good plus bad packets completed; saturating.
- chk_err_cnt  out  CNT_W  bad packets; saturating.
- chk_seq_err  out  1  sticky flag.
- chk_data_err  out  1  sticky flag.
- chk_short_err  out  1  sticky flag.
- chk_long_err  out  1  sticky flag.
- chk_first_bad_word  out  DATA_W  first mismatching word captured since the last clear.

Behaviour:

Reset values:
- All outputs 0.
- FSM in IDLE.
- Internal first_pkt flag = 1.

Packet format:
- One packet = contiguous ADC_DATA_VALID-high words, then at least 1 valid-low cycle.
- Word 0 is the header {2'b10, seq[15:0]}.
- Words 1..L are payload, where L is decoded from rf_pkt_data_length at the header cycle.
- Expected payload word i (i = 0..L-1) = {1'b0, seq[7:0], i[8:0]}.

Sampling:
- ADC_DATA / ADC_DATA_VALID are sampled only while DATA_RD_EN = 1.
- DATA_RD_EN is registered: it rises 1 cycle after rf_chk_en is seen high and falls 1 cycle after rf_chk_en is seen low.

FSM states and transitions:
- IDLE:
  - DATA_RD_EN = 0.
  - rf_chk_en = 1 -> ARM.
- ARM:
  - DATA_RD_EN = 1; waits for valid.
  - Valid with ADC_DATA[17:16] = 2'b10 -> HDR processing happens in the same cycle, then go to PAYLOAD.
  - Valid with any other tag -> word discarded, stay in ARM (resync, no error).
- PAYLOAD: word index counter idx is 9 bits.
  - Each valid word is compared with the expected value.
  - A mismatch sets the packet-bad flag and chk_data_err.
  - The first mismatch since clear is captured in chk_first_bad_word.
  - Valid low while idx < L -> short packet: bad, set chk_short_err, go to ARM.
  - idx reaches L -> GAP.
- GAP:
  - Valid low -> packet complete, go to ARM.
  - Valid high -> long packet: bad, set chk_long_err, go to ARM. The extra words are discarded until valid drops (no header search while valid stays high).

Sequence check:
- Applied at the header, except when first_pkt = 1.
- Requires seq == prev_seq + 1 mod 2^16; otherwise the packet is bad and chk_seq_err is set.
- first_pkt is cleared at the first header.
- first_pkt is set again on IDLE entry and on rf_chk_clear.

Packet completion (short, long or normal end):
- chk_pkt_cnt += 1.
- chk_err_cnt += 1 if the packet is bad; one count per packet regardless of how many errors it has.
- Both counters saturate at all-ones and never wrap.

Simultaneous events and aborts:
- rf_chk_clear has priority over an increment in the same cycle: counters read 0 on the next cycle.
- rf_chk_en low in any state -> IDLE next cycle. A partial packet is neither counted nor flagged.
- Async reset mid-packet returns every output to its reset value immediately.

Length select:
- rf_pkt_data_length changes take effect at the next header only.

Decomposition:
- Package pkt_rx_pkg:
  - state enum {IDLE, ARM, PAYLOAD, GAP}.
  - HDR_TAG = 2'b10.
  - function len_decode(2-bit) -> 10-bit word count.
  - function exp_payload(seq8, idx9).
- Sub-module pkt_rx_sat_cnt: CNT_W saturating counter with inc and sync clear; instantiated twice.

Test Plan:
1. Enable, length 0, three packets with seq 5, 6, 7 and correct payload -> chk_pkt_cnt = 3, chk_err_cnt = 0, all flags 0; DATA_RD_EN high 1 cycle after rf_chk_en.
2. Header seq 0x0010, payload word 3 = 18'h0 -> chk_data_err = 1, chk_err_cnt = 1, chk_first_bad_word = 18'h0.
3. Seq 9 followed by seq 11 -> chk_seq_err = 1, chk_err_cnt = 1; the first packet after enable is never flagged.
4. Length 1, valid drops after 100 payload words -> chk_short_err = 1. Valid held high for 130 payload words -> chk_long_err = 1; chk_pkt_cnt = 2.
5. Force chk_pkt_cnt to 0xFFFE, send 3 packets -> holds 0xFFFF. rf_chk_clear coincident with a packet end -> counters read 0.
6. Drop rf_chk_en mid-payload -> IDLE, DATA_RD_EN = 0 the next cycle, counters unchanged. Re-enable -> the first header is not seq-checked.

Source files
------------

// File: rtl/pkt_rx_pkg.sv
// Shared types and helpers for the packet receive checker.
// Defines the state encoding, the header tag, the length decode and the payload pattern.
package pkt_rx_pkg;

  typedef enum logic [1:0] {IDLE, ARM, PAYLOAD, GAP} state_t;

  localparam logic [1:0] HDR_TAG = 2'b10;
  localparam int         WORD_W  = 18;

  // 0..3 selects 64/128/256/512 payload words
  function automatic logic [9:0] len_decode(input logic [1:0] sel);
    return 10'd64 << sel;
  endfunction

  function automatic logic [WORD_W-1:0] exp_payload(input logic [7:0] seq8,
                                                    input logic [8:0] idx9);
    return {1'b0, seq8, idx9};
  endfunction

endpackage

// File: rtl/pkt_rx_sat_cnt.sv
// Up-counter that sticks at all-ones; a synchronous clear wins over an increment.
module pkt_rx_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_rx_checker.sv
// Deframes the packetised ADC stream and checks header sequence, payload pattern and length,
// reporting saturating packet/error counts and sticky error flags.
module pkt_rx_checker
  import pkt_rx_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int CNT_W  = 16
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rstn,
  input  logic              rf_chk_en,
  input  logic              rf_chk_clear,
  input  logic [1:0]        rf_pkt_data_length,
  output logic              DATA_RD_EN,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              ADC_DATA_VALID,
  output logic              chk_busy,
  output logic [CNT_W-1:0]  chk_pkt_cnt,
  output logic [CNT_W-1:0]  chk_err_cnt,
  output logic              chk_seq_err,
  output logic              chk_data_err,
  output logic              chk_short_err,
  output logic              chk_long_err,
  output logic [DATA_W-1:0] chk_first_bad_word
);

  state_t      state, state_nx;
  logic [8:0]  idx;
  logic [9:0]  len_words;
  logic [15:0] prev_seq;
  logic        first_pkt, pkt_bad, drain;
  logic        hdr_hit, adv, word_bad, last_word;
  logic        set_seq, set_data, set_short, set_long;
  logic        done, done_bad;

  assign DATA_RD_EN = (state != IDLE);
  assign chk_busy   = (state == PAYLOAD);

  always_comb begin
    state_nx  = state;
    hdr_hit   = 1'b0;
    adv       = 1'b0;
    set_seq   = 1'b0;
    set_data  = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    done      = 1'b0;
    done_bad  = 1'b0;
    word_bad  = (ADC_DATA != DATA_W'(exp_payload(prev_seq[7:0], idx)));
    last_word = ({1'b0, idx} == (len_words - 10'd1));
    // Dropping the enable abandons any partial packet without counting or flagging it.
    if (!rf_chk_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = ARM;
        ARM: begin
          // drain swallows the tail of a long packet until valid drops
          if (ADC_DATA_VALID && !drain && (ADC_DATA[DATA_W-1 -: 2] == HDR_TAG)) begin
            hdr_hit  = 1'b1;
            set_seq  = !first_pkt && (ADC_DATA[15:0] != (prev_seq + 16'd1));
            state_nx = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (ADC_DATA_VALID) begin
            adv      = 1'b1;
            set_data = word_bad;
            if (last_word) state_nx = GAP;
          end else begin
            set_short = 1'b1;
            done      = 1'b1;
            done_bad  = 1'b1;
            state_nx  = ARM;
          end
        end
        GAP: begin
          done     = 1'b1;
          state_nx = ARM;
          if (ADC_DATA_VALID) begin
            set_long = 1'b1;
            done_bad = 1'b1;
          end else begin
            done_bad = pkt_bad;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
    if (!pktctrl_rstn) begin
      state              <= IDLE;
      idx                <= '0;
      first_pkt          <= 1'b1;
      pkt_bad            <= 1'b0;
      drain              <= 1'b0;
      chk_seq_err        <= 1'b0;
      chk_data_err       <= 1'b0;
      chk_short_err      <= 1'b0;
      chk_long_err       <= 1'b0;
      chk_first_bad_word <= '0;
    end else begin
      state <= state_nx;
      if (hdr_hit)  idx <= '0;
      else if (adv) idx <= idx + 9'd1;
      if (hdr_hit)       pkt_bad <= set_seq;
      else if (set_data) pkt_bad <= 1'b1;
      if (set_long)                           drain <= 1'b1;
      else if (!ADC_DATA_VALID || !rf_chk_en) drain <= 1'b0;
      if (rf_chk_clear || (state_nx == IDLE)) first_pkt <= 1'b1;
      else if (hdr_hit)                       first_pkt <= 1'b0;
      if (rf_chk_clear) begin
        chk_seq_err        <= 1'b0;
        chk_data_err       <= 1'b0;
        chk_short_err      <= 1'b0;
        chk_long_err       <= 1'b0;
        chk_first_bad_word <= '0;
      end else begin
        if (set_seq)   chk_seq_err   <= 1'b1;
        if (set_data)  chk_data_err  <= 1'b1;
        if (set_short) chk_short_err <= 1'b1;
        if (set_long)  chk_long_err  <= 1'b1;
        if (set_data && !chk_data_err) chk_first_bad_word <= ADC_DATA;
      end
    end
  end

  // Header fields live for the whole packet; a length change only lands at the next header.
  always_ff @(posedge pktctrl_clk) begin
    if (hdr_hit) begin
      prev_seq  <= ADC_DATA[15:0];
      len_words <= len_decode(rf_pkt_data_length);
    end
  end

  pkt_rx_sat_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk   (pktctrl_clk),
    .rst_n (pktctrl_rstn),
    .clr   (rf_chk_clear),
    .inc   (done),
    .cnt   (chk_pkt_cnt)
  );

  pkt_rx_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (pktctrl_clk),
    .rst_n (pktctrl_rstn),
    .clr   (rf_chk_clear),
    .inc   (done && done_bad),
    .cnt   (chk_err_cnt)
  );

endmodule
